// File: rtl/acc_cpu_param.sv
// rtl/acc_cpu_param.sv - parametrised accumulator CPU with memory ready handshake
//
// Purpose: single bus master running 3-bit-opcode accumulator code from a memory
// with wait states. Instruction format is opcode in the top 3 bits and address
// operand in the low DATA_W-3 bits.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   addr_bus   out  memory address (DATA_W-3 bits)
//   rd_mem     out  read request
//   wr_mem     out  write request
//   wr_data    out  write data (accumulator)
//   rd_data    in   read data, taken on an edge with rd_mem && mem_ready
//   mem_ready  in   memory completes the current request at this edge
//   halted     out  core is in HALT
//   bus_err    out  bus-timeout trap occurred
//   acc_dbg    out  accumulator
//
// Optional feature: define BUS_TIMEOUT_EN to trap into HALT with bus_err set
// when a request waits TIMEOUT_CYC stalled cycles and then stalls once more.
// Without it the core waits indefinitely and bus_err is 0.
module acc_cpu_param #(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-4:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-4:0] addr_bus,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              mem_ready,
  output logic              halted,
  output logic              bus_err,
  output logic [DATA_W-1:0] acc_dbg
);

  localparam int ADDR_W = DATA_W - 3;

  localparam logic [2:0] S_START  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXRD   = 3'd3;
  localparam logic [2:0] S_EXWR   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JEZ = 3'd5;
  localparam logic [2:0] OP_HLT = 3'd6;
  localparam logic [2:0] OP_JNG = 3'd7;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;

  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic              w_req_active;
  logic              w_timeout;

  assign w_opcode     = r_ir[DATA_W-1:DATA_W-3];
  assign w_operand    = r_ir[ADDR_W-1:0];
  assign w_req_active = (r_state == S_FETCH) || (r_state == S_EXRD) || (r_state == S_EXWR);

  // Bus outputs are a pure decode of the state, so they stay stable across wait states.
  always_comb begin
    addr_bus = '0;
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        addr_bus = r_pc;
        rd_mem   = 1'b1;
      end
      S_EXRD: begin
        addr_bus = w_operand;
        rd_mem   = 1'b1;
      end
      S_EXWR: begin
        addr_bus = w_operand;
        wr_mem   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign wr_data = r_acc;
  assign acc_dbg = r_acc;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  // Cleared whenever no request is pending or one completes, so every new
  // FETCH/EXRD/EXWR starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (!w_req_active || mem_ready) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != CNT_W'(TIMEOUT_CYC)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Completion on the limit edge wins: the trap requires mem_ready low.
  assign w_timeout = w_req_active && !mem_ready && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = |TIMEOUT_CYC;
  assign w_timeout    = 1'b0;
  assign bus_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_START;
      r_pc    <= RESET_PC;
      r_acc   <= '0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_START: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= rd_data;
            r_pc    <= r_pc + 1'b1;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_HALT;
          end
        end
        S_DECODE: begin
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB: r_state <= S_EXRD;
            OP_STA: r_state <= S_EXWR;
            OP_JMP: begin
              r_pc    <= w_operand;
              r_state <= S_FETCH;
            end
            OP_JEZ: begin
              if (r_acc == '0) r_pc <= w_operand;
              r_state <= S_FETCH;
            end
            OP_JNG: begin
              if (r_acc[DATA_W-1]) r_pc <= w_operand;
              r_state <= S_FETCH;
            end
            default: r_state <= S_HALT;
          endcase
        end
        S_EXRD: begin
          if (mem_ready) begin
            case (w_opcode)
              OP_ADD:  r_acc <= r_acc + rd_data;
              OP_SUB:  r_acc <= r_acc - rd_data;
              default: r_acc <= rd_data;
            endcase
            r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_HALT;
          end
        end
        S_EXWR: begin
          if (mem_ready) begin
            r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_HALT;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_START;
      endcase
    end
  end

endmodule
